// File: rtl/sorted_ram_writer_if.sv
// Bus between the sorted-table writer and its user: the level insert
// handshake, the clear request, the status flags and the read port.
interface sorted_ram_writer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              s;
   logic [DATA_W-1:0] a;
   logic              clear;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              done;
   logic              dropped;
   logic              full;
   logic [ADDR_W:0]   count;

   modport master (
      output s, a, clear, rd_addr,
      input  rd_data, done, dropped, full, count
   );

   modport slave (
      input  s, a, clear, rd_addr,
      output rd_data, done, dropped, full, count
   );
endinterface

// File: rtl/sorted_ram_writer.sv
// Insertion-sort writer: keeps mem[0..count-1] ascending (stable for equal
// values) by shifting larger entries up one slot per cycle, then dropping the
// new value into the hole. A registered read port returns mem[rd_addr] one
// cycle later so a search block can read this table like a synchronous RAM.
module sorted_ram_writer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input logic                clk,
   input logic                reset,
   sorted_ram_writer_if.slave bus
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_val;
   logic [DATA_W-1:0] r_rd_data;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W:0]   r_count;
   logic              r_dropped;

   logic              w_full;
   logic              w_clear;
   logic              w_load;
   logic              w_drop;
   logic              w_shift;
   logic              w_write;
   logic              w_release;
   logic [ADDR_W-1:0] w_idx_m1;
   logic [DATA_W-1:0] w_prev;

   assign w_full   = (r_count == LP_DEPTH);
   // idx-1 wraps when idx is 0, but the neighbour is only used when idx > 0.
   assign w_idx_m1 = r_idx - ADDR_W'(1);
   assign w_prev   = r_mem[w_idx_m1];

   assign bus.rd_data = r_rd_data;
   assign bus.done    = (r_state == ST_DONE);
   assign bus.dropped = r_dropped;
   assign bus.full    = w_full;
   assign bus.count   = r_count;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and the one-hot action strobes for the datapath.
   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_load    = 1'b0;
      w_drop    = 1'b0;
      w_shift   = 1'b0;
      w_write   = 1'b0;
      w_release = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.clear) begin
               w_clear = 1'b1;
            end else if (bus.s) begin
               if (w_full) begin
                  w_drop = 1'b1;
                  w_next = ST_DONE;
               end else begin
                  w_load = 1'b1;
                  w_next = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            // Strict compare keeps equal values below the new one (stable).
            if ((r_idx != '0) && (w_prev > r_val)) begin
               w_shift = 1'b1;
            end else begin
               w_write = 1'b1;
               w_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!bus.s) begin
               w_release = 1'b1;
               w_next    = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Insert bookkeeping: captured value, hole index, entry count, drop flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_val     <= '0;
         r_idx     <= '0;
         r_count   <= '0;
         r_dropped <= 1'b0;
      end else begin
         if (w_clear) begin
            r_count <= '0;
         end
         if (w_load) begin
            r_val <= bus.a;
            // Only loaded when not full, so count fits in ADDR_W bits here.
            r_idx <= r_count[ADDR_W-1:0];
         end
         if (w_shift) begin
            r_idx <= w_idx_m1;
         end
         if (w_write) begin
            r_count <= r_count + (ADDR_W+1)'(1);
         end
         if (w_drop) begin
            r_dropped <= 1'b1;
         end else if (w_release) begin
            r_dropped <= 1'b0;
         end
      end
   end

   // Table storage: cleared as a whole, otherwise one slot written per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_shift) begin
         r_mem[r_idx] <= w_prev;
      end else if (w_write) begin
         r_mem[r_idx] <= r_val;
      end
   end

   // Registered read port; returns pre-edge contents on a same-edge write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[bus.rd_addr];
      end
   end

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Bench for sorted_ram_writer: stimulus pushes expectations derived from a
// sorted-queue model into scoreboards; a monitor pops and compares them when
// done rises, when a read result is due, or when a status snapshot is due.
module tb_sorted_ram_writer;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef struct {
      int cyc;
      int dropped;
      int count;
   } ins_t;

   typedef struct {
      int due;
      int addr;
      int exp;
   } rd_t;

   typedef struct {
      int due;
      int count;
      int full;
      bit chk_rd;
   } st_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   logic [7:0] mq[$];
   ins_t       ins_q[$];
   rd_t        rd_q[$];
   st_t        st_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sorted_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sr ();

   sorted_ram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Status snapshot one cycle from now: idle, not done, not dropped.
   task automatic push_st(input bit chk_rd);
      st_t st;
      st.due    = cyc + 1;
      st.count  = mq.size();
      st.full   = (mq.size() == DEPTH);
      st.chk_rd = chk_rd;
      st_q.push_back(st);
   endtask

   // Insert v. early drops s right after sampling; hold keeps s high in DONE.
   task automatic ins(input logic [7:0] v, input bit early, input int hold);
      ins_t e;
      int   k;
      int   t;
      k = 0;
      foreach (mq[i]) if (mq[i] > v) k++;
      if (mq.size() == DEPTH) begin
         e.cyc = cyc + 1; e.dropped = 1; e.count = DEPTH;
      end else begin
         e.cyc = cyc + k + 2; e.dropped = 0; e.count = mq.size() + 1;
      end
      ins_q.push_back(e);
      sr.s = 1'b1;
      sr.a = v;
      @(negedge clk);
      sr.a = 8'($urandom);
      if (early) sr.s = 1'b0;
      t = 0;
      while (sr.done !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (sr.done !== 1'b1) chk("insert_timeout", {31'b0, sr.done}, 1);
      repeat (hold) @(negedge clk);
      sr.s = 1'b0;
      @(negedge clk);
      if (mq.size() < DEPTH) mq.insert(mq.size() - k, v);
      push_st(1'b0);
      @(negedge clk);
   endtask

   task automatic rd_all();
      rd_t r;
      for (int i = 0; i < DEPTH; i++) begin
         sr.rd_addr = ADDR_W'(i);
         r.due  = cyc + 1;
         r.addr = i;
         r.exp  = (i < mq.size()) ? int'(mq[i]) : 0;
         rd_q.push_back(r);
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic do_clear(input bit with_s);
      sr.clear = 1'b1;
      sr.s     = with_s;
      sr.a     = 8'($urandom);
      mq.delete();
      push_st(1'b0);
      repeat (2) @(negedge clk);
      sr.clear = 1'b0;
      sr.s     = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: compares whatever the scoreboards say is due at this edge.
   initial begin : monitor
      bit   prev_done;
      ins_t e;
      rd_t  r;
      st_t  st;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (sr.done === 1'b1 && !prev_done) begin
            if (ins_q.size() == 0) begin
               chk("done_unexpected", {31'b0, sr.done}, 0);
            end else begin
               e = ins_q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("done_dropped", {31'b0, sr.dropped}, e.dropped);
               chk("done_count", {26'b0, sr.count}, e.count);
               chk("done_full", {31'b0, sr.full}, (e.count == DEPTH) ? 1 : 0);
            end
         end
         prev_done = (sr.done === 1'b1);
         while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r = rd_q.pop_front();
            chk($sformatf("rd_data[%0d]", r.addr), {24'b0, sr.rd_data}, r.exp);
         end
         while (st_q.size() > 0 && st_q[0].due == cyc) begin
            st = st_q.pop_front();
            chk("st_count", {26'b0, sr.count}, st.count);
            chk("st_done", {31'b0, sr.done}, 0);
            chk("st_dropped", {31'b0, sr.dropped}, 0);
            chk("st_full", {31'b0, sr.full}, st.full);
            if (st.chk_rd) chk("st_rd_data", {24'b0, sr.rd_data}, 0);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      sr.s = 1'b0;
      sr.a = '0;
      sr.clear = 1'b0;
      sr.rd_addr = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      push_st(1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single insert into an empty table.
      ins(8'h40, 1'b0, 0);
      rd_all();

      // Small set with a duplicate.
      do_clear(1'b0);
      ins(8'd30, 1'b0, 0);
      ins(8'd10, 1'b0, 1);
      ins(8'd20, 1'b1, 0);
      ins(8'd10, 1'b0, 2);
      rd_all();

      // Descending fill: every insert walks the whole table.
      do_clear(1'b0);
      for (int i = 0; i < DEPTH; i++) ins(8'(255 - i), (i % 5) == 0, 0);
      rd_all();

      // Insert into a full table is rejected.
      ins(8'h00, 1'b0, 2);
      rd_all();

      // Randomized inserts with many duplicates, then fill past full.
      do_clear(1'b0);
      repeat (20) begin
         ins(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7) * 32) : 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      end
      rd_all();
      while (mq.size() < DEPTH) ins(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      ins(8'($urandom), 1'b0, 0);
      rd_all();

      // Reset while an insert is shifting (k=5).
      do_clear(1'b0);
      for (int i = 0; i < 5; i++) ins(8'(100 + i), 1'b0, 0);
      sr.s = 1'b1;
      sr.a = 8'd50;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      ins_q.delete();
      mq.delete();
      push_st(1'b1);
      @(negedge clk);
      reset = 1'b0;
      sr.s = 1'b0;
      @(negedge clk);
      rd_all();

      // Clear wins over s in IDLE, then a normal insert.
      ins(8'd3, 1'b0, 0);
      ins(8'd1, 1'b0, 0);
      ins(8'd2, 1'b0, 0);
      rd_all();
      do_clear(1'b1);
      rd_all();
      ins(8'h55, 1'b0, 0);
      rd_all();

      repeat (3) @(negedge clk);
      chk("ins_q_drained", ins_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("st_q_drained", st_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sorted_ram_writer.md
Name: sorted_ram_writer

Overview:
- Insertion-sort writer that builds the sorted 32x8 table that the binary-search reader (task2) walks.
- Each accepted byte is inserted in ascending order by shifting larger entries up one slot per cycle.
- A registered read port with 1-cycle latency lets the search block read the table exactly as it reads its RAM.
- Uses the lab's level handshake: s is held high, done is asserted, and s must drop before the next insert.

Parameters:
- DATA_W, 8, width of a stored entry.
- ADDR_W, 5, address width.
- DEPTH, 32, number of entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- s  input  1  start/hold; level-sensitive, sampled only in IDLE and DONE.
- a  input  DATA_W  value to insert; sampled on the edge that leaves IDLE.
- clear  input  1  empties the table; honoured only in IDLE.
- rd_addr  input  ADDR_W  read address from the search block.
- rd_data  output  DATA_W  registered mem[rd_addr].
- done  output  1  high only in state DONE.
- dropped  output  1  high in DONE when the insert was rejected because the table was full.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  number of valid entries, 0..32.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; count=0; all mem entries=0.
  - done=0, dropped=0, rd_data=0.
  - Reset mid-insert aborts the insert; the table is left empty.
- Storage: register array mem[0..DEPTH-1]. Valid entries are mem[0..count-1], ascending and non-decreasing.
- Read port:
  - Every edge, in all states: rd_data <= mem[rd_addr] (pre-edge contents).
  - When rd_addr is written on the same edge, rd_data returns the old value.
  - rd_addr >= count returns whatever is stored there: 0 after reset/clear, otherwise stale.
- State IDLE:
  - clear=1 (has priority over s): count<=0, all mem<=0, stay IDLE.
  - else s=1 and full=1: dropped<=1, go DONE, no memory change.
  - else s=1: val<=a, idx<=count, go SHIFT.
- State SHIFT, one step per cycle:
  - If idx>0 and mem[idx-1] > val (unsigned, strict): mem[idx]<=mem[idx-1], idx<=idx-1.
  - Otherwise: mem[idx]<=val, count<=count+1, go DONE.
- State DONE:
  - done=1.
  - While s=1, stay in DONE.
  - When s=0: go IDLE and clear dropped.
  - clear is ignored in DONE.
- Latency: with k valid entries strictly greater than a, the write occurs on edge k+1 after the sampling edge, and done rises after that edge. Total is k+2 edges from sampling s.
  - Best case (k=0): 2 edges.
  - Worst case (k=31): 33 edges.
- Duplicates: a new value equal to existing entries lands after them; insertion is stable.
- Boundaries:
  - Empty table: the first insert writes mem[0] on edge 1 after sampling.
  - 32nd insert sets full.
  - 33rd insert is rejected with dropped=1, and count stays 32.
- a changing after the sampling edge has no effect. s dropping mid-SHIFT has no effect; the insert completes and done pulses for one cycle.
- count never wraps. mem[DEPTH] is never addressed, because SHIFT is only entered with count<DEPTH.

Test Plan:
- Reset, then insert 8'h40 (s held) -> done rises 2 edges after sampling; count=1; rd_addr=0 gives rd_data=8'h40 one cycle later.
- Insert 30,10,20,10 (decimal), releasing s between inserts -> mem[0..3]=10,10,20,30; count=4; 4th insert done after 2+2 edges (k=2).
- Insert 32 descending values 255..224 -> each insert takes count+2 edges; final mem[i]=224+i; full=1.
- With the table full, insert 8'h00 -> done after 1 edge; dropped=1; count=32; mem unchanged; dropped clears when s drops.
- Mid-SHIFT (k=5), assert reset for 1 cycle -> state IDLE, count=0, done=0; rd_data=0 for all addresses.
- clear=1 with s=1 in IDLE, table holding 3 entries -> count=0, all entries 0, no insert, done stays 0. Then clear=0 -> insert proceeds normally.
